// File: rtl/round_key_sequencer.sv
// Holds a 16 x 48-bit subkey bundle and serves one subkey per round handshake.
// Held keys are reused for every block until reloaded, flushed or reset.
module round_key_sequencer (
    input  logic         clk,
    input  logic         rst,
    input  logic         keys_valid_i,
    input  logic [767:0] round_keys_i,
    output logic         keys_ready_o,
    input  logic         block_start_i,
    input  logic         flush_i,
    output logic         subkey_valid_o,
    input  logic         subkey_ready_i,
    output logic [47:0]  subkey_o,
    output logic [3:0]   round_idx_o,
    output logic         last_round_o,
    output logic         block_done_o,
    output logic         start_err_o,
    output logic [15:0]  block_cnt_o
);

    typedef enum logic [1:0] {EMPTY, LOADED, SERVE} state_t;

    state_t            r_state, w_state_nxt;
    // Element [15] is round 0 (bits 767:720), element [0] is round 15.
    logic [15:0][47:0] r_keys, w_keys_nxt;
    logic [3:0]        r_idx, w_idx_nxt;
    logic [15:0]       r_cnt, w_cnt_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic              r_rdy_en;
    logic              w_load;
    logic              w_serve;

    assign w_serve      = (r_state == SERVE);
    assign keys_ready_o = r_rdy_en && !w_serve;
    assign w_load       = keys_valid_i && keys_ready_o;

    assign subkey_valid_o = w_serve;
    assign subkey_o       = w_serve ? r_keys[4'd15 - r_idx] : 48'h0;
    assign round_idx_o    = w_serve ? r_idx : 4'd0;
    assign last_round_o   = w_serve && (r_idx == 4'd15);
    assign block_done_o   = r_done;
    assign start_err_o    = r_err;
    assign block_cnt_o    = r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_keys_nxt  = r_keys;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (flush_i) begin
            w_state_nxt = EMPTY;
            w_keys_nxt  = '0;
            w_idx_nxt   = 4'd0;
            w_cnt_nxt   = 16'd0;
        end else begin
            case (r_state)
                EMPTY: begin
                    w_err_nxt = block_start_i;
                    if (w_load) begin
                        w_state_nxt = LOADED;
                        w_keys_nxt  = round_keys_i;
                        w_cnt_nxt   = 16'd0;
                    end
                end
                LOADED: begin
                    // A load in the same cycle as a start wins; the start is reported.
                    if (w_load) begin
                        w_keys_nxt = round_keys_i;
                        w_cnt_nxt  = 16'd0;
                        w_err_nxt  = block_start_i;
                    end else if (block_start_i) begin
                        w_state_nxt = SERVE;
                        w_idx_nxt   = 4'd0;
                    end
                end
                SERVE: begin
                    w_err_nxt = block_start_i;
                    if (subkey_ready_i) begin
                        if (r_idx == 4'd15) begin
                            w_state_nxt = LOADED;
                            w_idx_nxt   = 4'd0;
                            w_done_nxt  = 1'b1;
                            if (r_cnt != 16'hFFFF)
                                w_cnt_nxt = r_cnt + 16'd1;
                        end else begin
                            w_idx_nxt = r_idx + 4'd1;
                        end
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= EMPTY;
            r_keys   <= '0;
            r_idx    <= 4'd0;
            r_cnt    <= 16'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_keys   <= w_keys_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_rdy_en <= 1'b1;
        end
    end

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_round_key_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         kv = 1'b0;
    logic [767:0] rk = '0;
    logic         bs = 1'b0;
    logic         fl = 1'b0;
    logic         sr = 1'b0;
    logic         ready, valid, last, done, err;
    logic [47:0]  sub;
    logic [3:0]   idx;
    logic [15:0]  cnt;

    int n_cmp = 0;
    int n_bad = 0;

    round_key_sequencer dut (
        .clk(clk), .rst(rst),
        .keys_valid_i(kv), .round_keys_i(rk), .keys_ready_o(ready),
        .block_start_i(bs), .flush_i(fl),
        .subkey_valid_o(valid), .subkey_ready_i(sr), .subkey_o(sub),
        .round_idx_o(idx), .last_round_o(last), .block_done_o(done),
        .start_err_o(err), .block_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round r (0-based) carries off + ((r+1) mod 16) in its 48-bit slot.
    function automatic logic [47:0] exp_key(input logic [47:0] off, input int r);
        logic [4:0] k;
        k = 5'(r + 1);
        return off + {44'h0, k[3:0]};
    endfunction

    function automatic logic [767:0] seq_bundle(input logic [47:0] off);
        logic [767:0] b;
        for (int r = 0; r < 16; r++) b[767-48*r -: 48] = exp_key(off, r);
        return b;
    endfunction

    task automatic do_load(input logic [767:0] b);
        kv = 1'b1; rk = b;
        step();
        kv = 1'b0;
    endtask

    task automatic test_reset();
        kv = 0; bs = 0; fl = 0; sr = 0;
        rst = 1'b1;
        #3;
        n_cmp++;
        if ({ready, valid, sub, idx, last, done, err, cnt} !== 73'h0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h want=0", {ready, valid, sub, idx, last, done, err, cnt});
        end
        step(); step();
        rst = 1'b0;
        n_cmp++;
        if (ready !== 1'b0) begin n_bad++; $display("FAIL ready_before_edge got=%b want=0", ready); end
        step();
        n_cmp++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            n_bad++; $display("FAIL ready_after_edge got=%b/%b want=1/0", ready, valid);
        end
    endtask

    task automatic test_basic();
        do_load(seq_bundle(48'h0));
        n_cmp++;
        if (cnt !== 16'd0 || valid !== 1'b0 || ready !== 1'b1) begin
            n_bad++; $display("FAIL basic_loaded cnt=%0d valid=%b ready=%b want 0/0/1", cnt, valid, ready);
        end
        bs = 1'b1; step(); bs = 1'b0;
        sr = 1'b1;
        for (int r = 0; r < 16; r++) begin
            n_cmp++;
            if (valid !== 1'b1 || sub !== exp_key(48'h0, r) || idx !== 4'(r) ||
                last !== (r == 15) || done !== 1'b0 || err !== 1'b0) begin
                n_bad++;
                $display("FAIL basic_round%0d got v=%b k=%h i=%0d l=%b d=%b e=%b want k=%h", r,
                         valid, sub, idx, last, done, err, exp_key(48'h0, r));
            end
            step();
        end
        sr = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || valid !== 1'b0 || cnt !== 16'd1 || ready !== 1'b1) begin
            n_bad++; $display("FAIL basic_done d=%b v=%b cnt=%0d r=%b want 1/0/1/1", done, valid, cnt, ready);
        end
        step();
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_stall();
        bs = 1'b1; step(); bs = 1'b0;
        for (int c = 0; c < 32; c++) begin
            sr = (c % 2 == 1);
            n_cmp++;
            if (valid !== 1'b1 || sub !== exp_key(48'h0, c / 2) || idx !== 4'(c / 2) ||
                last !== (c / 2 == 15) || done !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_c%0d got k=%h i=%0d l=%b d=%b want k=%h i=%0d", c, sub, idx, last,
                         done, exp_key(48'h0, c / 2), c / 2);
            end
            step();
        end
        sr = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || cnt !== 16'd2) begin
            n_bad++; $display("FAIL stall_done d=%b cnt=%0d want 1/2", done, cnt);
        end
        step();
    endtask

    task automatic test_load_during_serve();
        bs = 1'b1; step(); bs = 1'b0;
        sr = 1'b1;
        for (int r = 0; r < 5; r++) step();
        sr = 1'b0;
        kv = 1'b1; rk = seq_bundle(48'h100);
        n_cmp++;
        if (ready !== 1'b0 || idx !== 4'd5) begin
            n_bad++; $display("FAIL lds_ready got r=%b i=%0d want 0/5", ready, idx);
        end
        step();
        kv = 1'b0;
        sr = 1'b1;
        for (int r = 5; r < 16; r++) begin
            n_cmp++;
            if (sub !== exp_key(48'h0, r) || idx !== 4'(r)) begin
                n_bad++; $display("FAIL lds_old_round%0d got=%h want=%h", r, sub, exp_key(48'h0, r));
            end
            step();
        end
        sr = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || cnt !== 16'd3 || ready !== 1'b1) begin
            n_bad++; $display("FAIL lds_done d=%b cnt=%0d r=%b want 1/3/1", done, cnt, ready);
        end
        do_load(seq_bundle(48'h100));
        n_cmp++;
        if (cnt !== 16'd0) begin n_bad++; $display("FAIL lds_cnt_clear got=%0d want=0", cnt); end
        bs = 1'b1; step(); bs = 1'b0;
        n_cmp++;
        if (sub !== exp_key(48'h100, 0)) begin
            n_bad++; $display("FAIL lds_new_key got=%h want=%h", sub, exp_key(48'h100, 0));
        end
        sr = 1'b1;
        for (int r = 0; r < 16; r++) step();
        sr = 1'b0;
    endtask

    task automatic test_start_err();
        fl = 1'b1; step(); fl = 1'b0;
        bs = 1'b1; step(); bs = 1'b0;
        n_cmp++;
        if (err !== 1'b1 || valid !== 1'b0 || ready !== 1'b1) begin
            n_bad++; $display("FAIL err_empty e=%b v=%b r=%b want 1/0/1", err, valid, ready);
        end
        step();
        n_cmp++;
        if (err !== 1'b0 || valid !== 1'b0) begin
            n_bad++; $display("FAIL err_empty_pulse e=%b v=%b want 0/0", err, valid);
        end
        do_load(seq_bundle(48'h0));
        kv = 1'b1; bs = 1'b1; rk = seq_bundle(48'h200);
        step();
        kv = 1'b0; bs = 1'b0;
        n_cmp++;
        if (err !== 1'b1 || valid !== 1'b0 || ready !== 1'b1) begin
            n_bad++; $display("FAIL err_load_start e=%b v=%b r=%b want 1/0/1", err, valid, ready);
        end
        bs = 1'b1; step(); bs = 1'b0;
        n_cmp++;
        if (sub !== exp_key(48'h200, 0) || err !== 1'b0) begin
            n_bad++; $display("FAIL err_load_won k=%h e=%b want %h/0", sub, err, exp_key(48'h200, 0));
        end
        bs = 1'b1; step(); bs = 1'b0;
        n_cmp++;
        if (err !== 1'b1 || valid !== 1'b1 || idx !== 4'd0) begin
            n_bad++; $display("FAIL err_serve e=%b v=%b i=%0d want 1/1/0", err, valid, idx);
        end
        sr = 1'b1;
        for (int r = 0; r < 16; r++) step();
        sr = 1'b0;
    endtask

    task automatic test_flush();
        bs = 1'b1; step(); bs = 1'b0;
        sr = 1'b1;
        for (int r = 0; r < 7; r++) step();
        n_cmp++;
        if (idx !== 4'd7 || cnt === 16'd0) begin
            n_bad++; $display("FAIL flush_pre i=%0d cnt=%0d want 7/nonzero", idx, cnt);
        end
        fl = 1'b1; kv = 1'b1; rk = seq_bundle(48'h300);
        step();
        fl = 1'b0; kv = 1'b0; sr = 1'b0;
        n_cmp++;
        if ({valid, sub, idx, last, done, err, cnt} !== 72'h0 || ready !== 1'b1) begin
            n_bad++; $display("FAIL flush_state got=%h r=%b want 0/1", {valid, sub, idx, last, done, err, cnt}, ready);
        end
        bs = 1'b1; step(); bs = 1'b0;
        n_cmp++;
        if (err !== 1'b1 || valid !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL flush_start_err e=%b v=%b d=%b want 1/0/0", err, valid, done);
        end
        step();
    endtask

    task automatic test_async_reset();
        do_load(seq_bundle(48'h0));
        bs = 1'b1; step(); bs = 1'b0;
        sr = 1'b1;
        for (int r = 0; r < 3; r++) step();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ready, valid, sub, idx, last, done, err, cnt} !== 73'h0) begin
            n_bad++; $display("FAIL areset_immediate got=%h want=0", {ready, valid, sub, idx, last, done, err, cnt});
        end
        step();
        sr = 1'b0;
        n_cmp++;
        if ({ready, valid, sub, idx, last, done, err, cnt} !== 73'h0) begin
            n_bad++; $display("FAIL areset_held got=%h want=0", {ready, valid, sub, idx, last, done, err, cnt});
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (ready !== 1'b1 || valid !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL areset_release r=%b v=%b d=%b want 1/0/0", ready, valid, done);
        end
        bs = 1'b1; step(); bs = 1'b0;
        n_cmp++;
        if (err !== 1'b1 || valid !== 1'b0) begin
            n_bad++; $display("FAIL areset_empty e=%b v=%b want 1/0", err, valid);
        end
    endtask

    // Model: a bundle is an array of 16 keys; a block in flight is the queue of rounds still owed.
    task automatic test_random();
        bit          m_rdy, m_have, m_done, m_err, serving, ld;
        logic [47:0] m_k[16];
        int          q[$];
        int          m_cnt;
        logic [72:0] e, g;
        kv = 0; bs = 0; fl = 0; sr = 0;
        rst = 1'b1; step(); rst = 1'b0;
        m_rdy = 0; m_have = 0; m_done = 0; m_err = 0; m_cnt = 0;
        foreach (m_k[i]) m_k[i] = '0;
        for (int c = 0; c < 3000; c++) begin
            kv = ($urandom_range(0, 3) == 0);
            for (int w = 0; w < 24; w++) rk[32*w +: 32] = $urandom;
            bs = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 49) == 0);
            sr = ($urandom_range(0, 9) < 6);
            e = {m_rdy && q.size() == 0, q.size() != 0,
                 (q.size() != 0) ? m_k[q[0]] : 48'h0,
                 (q.size() != 0) ? 4'(q[0]) : 4'd0,
                 q.size() != 0 && q[0] == 15, m_done, m_err, 16'(m_cnt)};
            g = {ready, valid, sub, idx, last, done, err, cnt};
            n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL random_c%0d got=%h want=%h", c, g, e);
            end
            serving = (q.size() != 0);
            ld = kv && m_rdy && !serving;
            m_done = 0; m_err = 0;
            if (fl) begin
                m_have = 0; q.delete(); m_cnt = 0;
                foreach (m_k[i]) m_k[i] = '0;
            end else begin
                m_err = bs && (ld || !m_have || serving);
                if (ld) begin
                    for (int r = 0; r < 16; r++) m_k[r] = rk[767-48*r -: 48];
                    m_have = 1; m_cnt = 0;
                end else if (bs && m_have && !serving) begin
                    for (int r = 0; r < 16; r++) q.push_back(r);
                end
                if (serving && sr) begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        m_done = 1;
                        if (m_cnt < 65535) m_cnt++;
                    end
                end
            end
            m_rdy = 1;
            step();
        end
        kv = 0; bs = 0; fl = 0; sr = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_load_during_serve();
        test_start_err();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
